global_pool_runner: RTL and testbench

- Successor to the single-mode global-average-pool runner.
- Reduces each channel of a CHW int8 tensor (H*W elements) to one value: average (sum, then requant) or max.
- Supports pipelined memory reads of configurable latency and output backpressure.
- Sits between the activation buffer and the FC/classifier stage; per-channel quant coefficients come from the external table via ch_idx.

---
 rtl/global_pool_runner.sv | 235 +++++++++++++++++++++++
 tb/tb_global_pool_runner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_pool_runner.sv
// Per-channel global pooling engine: average (sum + requant) or max over an
// H*W int8 plane, with a fixed-latency read pipeline and a ready/valid write.
module global_pool_runner #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ACC_W   = 32,
    parameter int unsigned MUL_W   = 16,
    parameter int unsigned BIAS_W  = 32,
    parameter int unsigned SHIFT_W = 6,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DIM_W   = 16,
    parameter int unsigned RD_LAT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    input  logic               cfg_mode,
    input  logic [DIM_W-1:0]   cfg_in_h,
    input  logic [DIM_W-1:0]   cfg_in_w,
    input  logic [DIM_W-1:0]   cfg_in_c,
    input  logic [ADDR_W-1:0]  cfg_in_base,
    input  logic [ADDR_W-1:0]  cfg_out_base,
    output logic               in_rd_en,
    output logic [ADDR_W-1:0]  in_rd_addr,
    input  logic [DATA_W-1:0]  in_rd_data,
    output logic               out_wr_valid,
    input  logic               out_wr_ready,
    output logic [ADDR_W-1:0]  out_wr_addr,
    output logic [DATA_W-1:0]  out_wr_data,
    output logic [DIM_W-1:0]   ch_idx,
    input  logic [MUL_W-1:0]   ch_mul,
    input  logic [BIAS_W-1:0]  ch_bias,
    input  logic [SHIFT_W-1:0] ch_shift
);

    localparam int unsigned N_W    = 2 * DIM_W;
    localparam int unsigned PROD_W = ACC_W + MUL_W;
    localparam int unsigned RES_W  = PROD_W + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_Q1    = 3'd3;
    localparam logic [2:0] S_Q2    = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_NEXT  = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_HI  = RES_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [RES_W-1:0] SAT_LO  = ~SAT_HI;

    logic [2:0]                state_q, state_d;
    logic                      mode_q, mode_d;
    logic [N_W-1:0]            n_q, n_d;
    logic [N_W-1:0]            cnt_q, cnt_d;
    logic [DIM_W-1:0]          c_q, c_d;
    logic [DIM_W-1:0]          ch_idx_q, ch_idx_d;
    logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]         out_base_q, out_base_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [RD_LAT-1:0]         vld_q, vld_d;
    logic signed [PROD_W-1:0]  prod_q, prod_d;
    logic signed [BIAS_W-1:0]  bias_q, bias_d;
    logic [SHIFT_W-1:0]        shift_q, shift_d;
    logic [DATA_W-1:0]         res_q, res_d;

    logic signed [ACC_W-1:0]   data_ext;
    logic signed [PROD_W-1:0]  acc_x, mul_x;
    logic signed [PROD_W-1:0]  shifted;
    logic                      round_bit;
    logic signed [RES_W-1:0]   scaled;
    logic [DATA_W-1:0]         sat_val;

    // Outputs decoded from state and registered datapath values
    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign in_rd_en     = (state_q == S_ISSUE);
    assign in_rd_addr   = in_rd_en ? rd_addr_q : '0;
    assign out_wr_valid = (state_q == S_WRITE);
    assign out_wr_addr  = out_wr_valid ? (out_base_q + ADDR_W'(ch_idx_q)) : '0;
    assign out_wr_data  = out_wr_valid ? res_q : '0;
    assign ch_idx       = ch_idx_q;

    assign data_ext = {{(ACC_W - DATA_W){in_rd_data[DATA_W-1]}}, in_rd_data};
    assign acc_x    = PROD_W'(acc_q);
    assign mul_x    = PROD_W'($signed(ch_mul));

    // Requant: round-half-up arithmetic shift (floor shift plus the last bit shifted out), bias, saturate
    always_comb begin
        shifted   = prod_q >>> shift_q;
        round_bit = 1'b0;
        if (shift_q != '0) begin
            round_bit = 1'(prod_q >>> (shift_q - SHIFT_W'(1)));
        end
        scaled = RES_W'(shifted) + RES_W'(bias_q) + RES_W'({1'b0, round_bit});
        if (scaled > SAT_HI) begin
            sat_val = SAT_HI[DATA_W-1:0];
        end else if (scaled < SAT_LO) begin
            sat_val = SAT_LO[DATA_W-1:0];
        end else begin
            sat_val = scaled[DATA_W-1:0];
        end
    end

    // Next-state, read pipeline tracking and datapath updates
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        c_d        = c_q;
        ch_idx_d   = ch_idx_q;
        rd_addr_d  = rd_addr_q;
        out_base_d = out_base_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        bias_d     = bias_q;
        shift_d    = shift_q;
        res_d      = res_q;
        vld_d      = RD_LAT'({vld_q, (state_q == S_ISSUE)});

        // absorb one read return
        if (vld_q[RD_LAT-1]) begin
            if (mode_q) begin
                if (data_ext > acc_q) acc_d = data_ext;
            end else begin
                acc_d = acc_q + data_ext;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = cfg_mode;
                    n_d        = N_W'(cfg_in_h) * N_W'(cfg_in_w);
                    c_d        = cfg_in_c;
                    rd_addr_d  = cfg_in_base;
                    out_base_d = cfg_out_base;
                    ch_idx_d   = '0;
                    cnt_d      = '0;
                    acc_d      = cfg_mode ? ACC_MIN : '0;
                    if (cfg_in_h == '0 || cfg_in_w == '0 || cfg_in_c == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (cnt_q == n_q - N_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_DRAIN;
                end else begin
                    cnt_d = cnt_q + N_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == N_W'(RD_LAT - 1)) begin
                    cnt_d   = '0;
                    state_d = S_Q1;
                end else begin
                    cnt_d = cnt_q + N_W'(1);
                end
            end
            S_Q1: begin
                prod_d  = acc_x * mul_x;
                bias_d  = $signed(ch_bias);
                shift_d = ch_shift;
                state_d = S_Q2;
            end
            S_Q2: begin
                res_d   = mode_q ? acc_q[DATA_W-1:0] : sat_val;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (out_wr_ready) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (ch_idx_q == c_q - DIM_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_idx_d = ch_idx_q + DIM_W'(1);
                    acc_d    = mode_q ? ACC_MIN : '0;
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            n_q        <= '0;
            cnt_q      <= '0;
            c_q        <= '0;
            ch_idx_q   <= '0;
            rd_addr_q  <= '0;
            out_base_q <= '0;
            acc_q      <= '0;
            vld_q      <= '0;
            prod_q     <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            res_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            c_q        <= c_d;
            ch_idx_q   <= ch_idx_d;
            rd_addr_q  <= rd_addr_d;
            out_base_q <= out_base_d;
            acc_q      <= acc_d;
            vld_q      <= vld_d;
            prod_q     <= prod_d;
            bias_q     <= bias_d;
            shift_q    <= shift_d;
            res_q      <= res_d;
        end
    end

endmodule

// File: tb/tb_global_pool_runner.sv
// Bench for global_pool_runner: two instances (read latency 1 and 3) share a
// behavioural memory and coefficient table; results checked against a model.
module tb_global_pool_runner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_w [2];
    logic        busy_w [2];
    logic        done_w [2];
    logic        cfg_mode;
    logic [15:0] cfg_in_h, cfg_in_w, cfg_in_c;
    logic [31:0] cfg_in_base, cfg_out_base;
    logic        rd_en_w [2];
    logic [31:0] rd_addr_w [2];
    logic [7:0]  rd_data_w [2];
    logic        wr_valid_w [2];
    logic        out_wr_ready;
    logic [31:0] wr_addr_w [2];
    logic [7:0]  wr_data_w [2];
    logic [15:0] ch_idx_w [2];
    logic [15:0] ch_mul_w [2];
    logic [31:0] ch_bias_w [2];
    logic [5:0]  ch_shift_w [2];

    logic [7:0]  mem [256];
    int          mul_t [8];
    int          bias_t [8];
    int          shift_t [8];
    int          lat_t [2];

    int          checks = 0;
    int          failures = 0;
    int          sel = 0;

    logic [31:0] ra_q [$];
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];
    logic        dq [$];

    logic [31:0] pa [2][3];
    logic        pv [2][3];
    logic [7:0]  junk;

    always #5 clk = ~clk;

    global_pool_runner #(.RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .start(start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
        .cfg_mode(cfg_mode), .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_in_c(cfg_in_c),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .in_rd_en(rd_en_w[0]), .in_rd_addr(rd_addr_w[0]), .in_rd_data(rd_data_w[0]),
        .out_wr_valid(wr_valid_w[0]), .out_wr_ready(out_wr_ready),
        .out_wr_addr(wr_addr_w[0]), .out_wr_data(wr_data_w[0]), .ch_idx(ch_idx_w[0]),
        .ch_mul(ch_mul_w[0]), .ch_bias(ch_bias_w[0]), .ch_shift(ch_shift_w[0])
    );

    global_pool_runner #(.RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .start(start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
        .cfg_mode(cfg_mode), .cfg_in_h(cfg_in_h), .cfg_in_w(cfg_in_w), .cfg_in_c(cfg_in_c),
        .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
        .in_rd_en(rd_en_w[1]), .in_rd_addr(rd_addr_w[1]), .in_rd_data(rd_data_w[1]),
        .out_wr_valid(wr_valid_w[1]), .out_wr_ready(out_wr_ready),
        .out_wr_addr(wr_addr_w[1]), .out_wr_data(wr_data_w[1]), .ch_idx(ch_idx_w[1]),
        .ch_mul(ch_mul_w[1]), .ch_bias(ch_bias_w[1]), .ch_shift(ch_shift_w[1])
    );

    // Coefficient table lookup keyed by each instance's channel index
    assign ch_mul_w[0]   = 16'(mul_t[ch_idx_w[0][2:0]]);
    assign ch_bias_w[0]  = 32'(bias_t[ch_idx_w[0][2:0]]);
    assign ch_shift_w[0] = 6'(shift_t[ch_idx_w[0][2:0]]);
    assign ch_mul_w[1]   = 16'(mul_t[ch_idx_w[1][2:0]]);
    assign ch_bias_w[1]  = 32'(bias_t[ch_idx_w[1][2:0]]);
    assign ch_shift_w[1] = 6'(shift_t[ch_idx_w[1][2:0]]);

    // Memory with fixed read latency; random junk on the bus when no return is due
    always @(posedge clk) begin
        junk <= 8'($urandom);
        for (int i = 0; i < 2; i++) begin
            pv[i][0] <= rd_en_w[i];
            pa[i][0] <= rd_addr_w[i];
            for (int k = 1; k < 3; k++) begin
                pv[i][k] <= pv[i][k-1];
                pa[i][k] <= pa[i][k-1];
            end
        end
    end
    assign rd_data_w[0] = pv[0][0] ? mem[pa[0][0][7:0]] : junk;
    assign rd_data_w[1] = pv[1][2] ? mem[pa[1][2][7:0]] : junk;

    // Record reads, accepted writes and done pulses of the selected instance
    always @(posedge clk) begin
        if (!rst) begin
            if (rd_en_w[sel]) ra_q.push_back(rd_addr_w[sel]);
            if (wr_valid_w[sel] && out_wr_ready) begin
                wa_q.push_back(wr_addr_w[sel]);
                wd_q.push_back(wr_data_w[sel]);
            end
            if (done_w[sel]) dq.push_back(1'b1);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pooled value of one channel computed straight from the arithmetic definition
    function automatic logic [7:0] model(input bit mode, input int n, input logic [31:0] base,
                                         input int ch);
        longint      acc;
        longint      v;
        longint      r;
        logic [31:0] a;
        byte         b;
        acc = mode ? -128 : 0;
        for (int k = 0; k < n; k++) begin
            a = base + 32'(ch * n + k);
            b = mem[a[7:0]];
            v = b;
            if (mode) begin
                if (v > acc) acc = v;
            end else begin
                acc += v;
            end
        end
        if (mode) begin
            r = acc;
        end else begin
            r = acc * longint'(mul_t[ch]);
            if (shift_t[ch] > 0) r = (r + (longint'(1) <<< (shift_t[ch] - 1))) >>> shift_t[ch];
            r += longint'(bias_t[ch]);
            if (r > 127) r = 127;
            if (r < -128) r = -128;
        end
        return r[7:0];
    endfunction

    task automatic check_idle_outputs(input int s, input string tag);
        check({tag, "_busy"}, 64'(busy_w[s]), 64'd0);
        check({tag, "_done"}, 64'(done_w[s]), 64'd0);
        check({tag, "_rd_en"}, 64'(rd_en_w[s]), 64'd0);
        check({tag, "_rd_addr"}, 64'(rd_addr_w[s]), 64'd0);
        check({tag, "_wr_valid"}, 64'(wr_valid_w[s]), 64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr_w[s]), 64'd0);
        check({tag, "_wr_data"}, 64'(wr_data_w[s]), 64'd0);
        check({tag, "_ch_idx"}, 64'(ch_idx_w[s]), 64'd0);
    endtask

    // Run one job on instance s, optionally holding off the first write for bp cycles
    task automatic run_job(input int s, input bit mode, input int h, input int w, input int c,
                           input logic [31:0] ib, input logic [31:0] ob, input int bp);
        int          cyc;
        int          held;
        bit          seen;
        int          n;
        int          exp_cyc;
        int          exp_wr;
        logic [31:0] ha;
        logic [7:0]  hd;
        n = h * w;
        sel = s;
        ra_q.delete(); wa_q.delete(); wd_q.delete(); dq.delete();
        cfg_mode = mode; cfg_in_h = 16'(h); cfg_in_w = 16'(w); cfg_in_c = 16'(c);
        cfg_in_base = ib; cfg_out_base = ob;
        start_w[s] = 1'b1;
        @(negedge clk);
        start_w[s] = 1'b0;
        cyc = 0; held = 0; seen = 0; ha = '0; hd = '0;
        while (!done_w[s] && cyc < 400) begin
            // a start pulse and config change mid-job must be ignored
            if (cyc == 3) begin
                start_w[s] = 1'b1; cfg_in_c = 16'd7; cfg_in_base = 32'h0000_dead; cfg_mode = ~mode;
            end else begin
                start_w[s] = 1'b0;
            end
            if (wr_valid_w[s] && !seen && bp > 0) begin
                seen = 1; ha = wr_addr_w[s]; hd = wr_data_w[s];
            end else if (seen && held < bp) begin
                held++;
                check("bp_valid_held", 64'(wr_valid_w[s]), 64'd1);
                check("bp_addr_held", 64'(wr_addr_w[s]), 64'(ha));
                check("bp_data_held", 64'(wr_data_w[s]), 64'(hd));
                check("bp_no_reads", 64'(rd_en_w[s]), 64'd0);
            end
            out_wr_ready = !(seen && held < bp);
            @(negedge clk);
            cyc++;
        end
        start_w[s] = 1'b0;
        out_wr_ready = 1'b1;
        check("done_seen", 64'(done_w[s]), 64'd1);
        if (h == 0 || w == 0 || c == 0) begin
            exp_cyc = 0; exp_wr = 0;
        end else begin
            exp_cyc = c * (n + lat_t[s] + 4) + bp; exp_wr = c;
        end
        check("latency", 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        check("done_one_cycle", 64'(done_w[s]), 64'd0);
        check("idle_after", 64'(busy_w[s]), 64'd0);
        check("done_count", 64'(dq.size()), 64'd1);
        check("read_count", 64'(ra_q.size()), 64'(exp_wr == 0 ? 0 : n * c));
        for (int k = 0; k < ra_q.size(); k++) check("read_addr", 64'(ra_q[k]), 64'(ib + 32'(k)));
        check("write_count", 64'(wa_q.size()), 64'(exp_wr));
        for (int k = 0; k < wa_q.size() && k < exp_wr; k++) begin
            check("write_addr", 64'(wa_q[k]), 64'(ob + 32'(k)));
            check("write_data", 64'(wd_q[k]), 64'(model(mode, n, ib, k)));
        end
    endtask

    task automatic set_coef(input int ch, input int mul, input int bias, input int sh);
        mul_t[ch] = mul; bias_t[ch] = bias; shift_t[ch] = sh;
    endtask

    initial begin
        lat_t[0] = 1; lat_t[1] = 3;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) set_coef(i, 1, 0, 0);
        rst = 1'b1; start_w[0] = 1'b0; start_w[1] = 1'b0; out_wr_ready = 1'b1;
        cfg_mode = 1'b0; cfg_in_h = '0; cfg_in_w = '0; cfg_in_c = '0;
        cfg_in_base = '0; cfg_out_base = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs(0, "reset_l1");
        check_idle_outputs(1, "reset_l3");
        rst = 1'b0;
        @(negedge clk);

        // average 2x2, data 1..4, 10*16384>>16 = 2.5 -> 3
        mem[8'h00] = 8'd1; mem[8'h01] = 8'd2; mem[8'h02] = 8'd3; mem[8'h03] = 8'd4;
        set_coef(0, 16384, 0, 16);
        run_job(0, 1'b0, 2, 2, 1, 32'h0000_0100, 32'h0000_2000, 0);
        check("avg_basic_value", 64'(wd_q[0]), 64'd3);

        // max over two channels
        mem[8'h40] = 8'hfb; mem[8'h41] = 8'd7; mem[8'h42] = 8'h80; mem[8'h43] = 8'd3;
        for (int i = 4; i < 8; i++) mem[8'h40 + i] = 8'h80;
        run_job(0, 1'b1, 2, 2, 2, 32'h0000_0040, 32'h0000_3000, 0);
        check("max_ch0", 64'(wd_q[0]), 64'h07);
        check("max_ch1", 64'(wd_q[1]), 64'h80);

        // positive and negative saturation
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'd127;
        set_coef(0, 16384, 0, 14);
        run_job(0, 1'b0, 2, 2, 1, 32'h0000_0080, 32'h0000_4000, 0);
        check("sat_pos", 64'(wd_q[0]), 64'h7f);
        for (int i = 0; i < 4; i++) mem[8'h80 + i] = 8'h80;
        set_coef(0, 16384, -10, 14);
        run_job(0, 1'b0, 2, 2, 1, 32'h0000_0080, 32'h0000_4000, 0);
        check("sat_neg", 64'(wd_q[0]), 64'h80);

        // latency-3 reads, 3x1 over two channels with bias
        mem[8'h10] = 8'd10; mem[8'h11] = 8'd20; mem[8'h12] = 8'd30;
        mem[8'h13] = 8'hff; mem[8'h14] = 8'hfe; mem[8'h15] = 8'hfd;
        set_coef(0, 1, 5, 0); set_coef(1, 1, 5, 0);
        run_job(1, 1'b0, 3, 1, 2, 32'h0000_0010, 32'h0000_5000, 0);
        check("lat3_ch0", 64'(wd_q[0]), 64'd65);
        check("lat3_ch1", 64'(wd_q[1]), 64'hff);

        // output backpressure for 5 cycles on the first write
        set_coef(0, 300, 7, 4); set_coef(1, -450, -3, 6);
        run_job(1, 1'b0, 2, 2, 2, 32'h0000_00a0, 32'h0000_6000, 5);

        // zero width: immediate done, no traffic
        run_job(0, 1'b0, 2, 0, 3, 32'h0000_0000, 32'h0000_7000, 0);

        // reset in the middle of ISSUE, then a fresh job
        sel = 1;
        cfg_mode = 1'b0; cfg_in_h = 16'd3; cfg_in_w = 16'd3; cfg_in_c = 16'd2;
        cfg_in_base = 32'h0000_0020; cfg_out_base = 32'h0000_8000;
        start_w[1] = 1'b1;
        @(negedge clk);
        start_w[1] = 1'b0;
        @(negedge clk);
        check("mid_issue_rd_en", 64'(rd_en_w[1]), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs(1, "mid_reset");
        rst = 1'b0;
        set_coef(0, 1000, 1, 8); set_coef(1, -77, 0, 3);
        run_job(1, 1'b0, 1, 3, 2, 32'h0000_0030, 32'h0000_9000, 0);

        // randomized jobs on both instances
        for (int j = 0; j < 8; j++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            for (int i = 0; i < 8; i++)
                set_coef(i, int'($urandom_range(0, 4000)) - 2000,
                         int'($urandom_range(0, 400)) - 200, int'($urandom_range(0, 20)));
            run_job(j % 2, 1'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                    int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                    $urandom, $urandom, (j == 5) ? 2 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
